// File: rtl/branch_ctrl.sv
// Branch controller: compare flag, jump-target LUT, and START/RUN/SQUASH/HALT sequencing.
// Optional BRANCH_CTR_EN adds a saturating 16-bit taken-branch counter output.
module branch_ctrl #(
  parameter int A         = 10,
  parameter int LUT_DEPTH = 16,
  localparam int IW       = $clog2(LUT_DEPTH)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          op_valid,
  input  logic          op_cmp,
  input  logic [7:0]    cmp_a,
  input  logic [7:0]    cmp_b,
  input  logic          op_beq,
  input  logic          op_jmp,
  input  logic          op_halt,
  input  logic [IW-1:0] lut_idx,
  input  logic          lut_wr_en,
  input  logic [IW-1:0] lut_wr_idx,
  input  logic [A-1:0]  lut_wr_data,
  output logic          beq_flag,
  output logic          jmp_flag,
  output logic [A-1:0]  Target,
  output logic          squash,
`ifdef BRANCH_CTR_EN
  output logic          done,
  output logic [15:0]   taken_count
`else
  output logic          done
`endif
);

  typedef enum logic [1:0] {START, RUN, SQUASH, HALT} state_t;

  state_t       state;
  state_t       state_nxt;
  logic         eq;
  logic         accept;
  logic         rd_ok;
  logic         wr_ok;
  logic [A-1:0] lut [LUT_DEPTH];

  // Widen by one bit so the range check stays meaningful for power-of-two depths.
  assign rd_ok = {1'b0, lut_idx} < (IW+1)'(LUT_DEPTH);
  assign wr_ok = {1'b0, lut_wr_idx} < (IW+1)'(LUT_DEPTH);
  assign Target = rd_ok ? lut[lut_idx] : '0;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    beq_flag  = 1'b0;
    jmp_flag  = 1'b0;
    squash    = 1'b0;
    done      = 1'b0;
    case (state)
      START:  state_nxt = RUN;
      RUN: begin
        accept   = op_valid;
        jmp_flag = op_valid & op_jmp & ~op_halt;
        beq_flag = op_valid & op_beq & eq & ~op_jmp & ~op_halt;
        if (op_valid && op_halt) begin
          state_nxt = HALT;
        end else if (jmp_flag || beq_flag) begin
          state_nxt = SQUASH;
        end
      end
      SQUASH: begin
        squash    = 1'b1;
        state_nxt = RUN;
      end
      HALT: begin
        done      = 1'b1;
        state_nxt = HALT;
      end
      default: state_nxt = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= START;
      eq    <= 1'b0;
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      // A branch in the same cycle has already consumed the old flag.
      if (accept && op_cmp) begin
        eq <= (cmp_a == cmp_b);
      end
      if (lut_wr_en && wr_ok) begin
        lut[lut_wr_idx] <= lut_wr_data;
      end
    end
  end

`ifdef BRANCH_CTR_EN
  logic [15:0] taken_count_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      taken_count_q <= '0;
    end else if ((beq_flag || jmp_flag) && taken_count_q != 16'hFFFF) begin
      taken_count_q <= taken_count_q + 16'd1;
    end
  end

  assign taken_count = taken_count_q;
`endif

endmodule
